// File: rtl/deser1_8.sv
// Serial-to-parallel deserializer: LSB-first bits are steered by a 3-bit index through a
// one-hot demux into a staging register; completed bytes go out on a valid/ready port.
module deser1_8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       frame_start,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clear_overrun,
  output logic [2:0] bit_idx
);

  logic [2:0] idx_q, idx_d;
  logic [7:0] stage_q, stage_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;

  logic [2:0] eidx;
  logic [7:0] wen;
  logic       complete;
  logic       hold_free;
  logic       drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 3'd0;
      stage_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    eidx      = frame_start ? 3'd0 : idx_q;
    wen       = bit_valid ? (8'b0000_0001 << eidx) : 8'h00;
    stage_d   = (stage_q & ~wen) | ({8{bit_in}} & wen);
    complete  = bit_valid && (eidx == 3'd7);
    hold_free = !valid_q || out_ready;
    drop      = complete && !hold_free;

    idx_d = idx_q;
    if (bit_valid) begin
      idx_d = eidx + 3'd1;
    end else if (frame_start) begin
      idx_d = 3'd0;
    end

    data_d  = data_q;
    valid_d = valid_q;
    if (complete && hold_free) begin
      data_d  = {bit_in, stage_q[6:0]};
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // A new drop wins over a simultaneous clear.
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_comb begin
    out_data  = data_q;
    out_valid = valid_q;
    overrun   = ovr_q;
    bit_idx   = idx_q;
  end

endmodule
